layer_scheduler: RTL and testbench
==================================

// Module: layer_scheduler
// PURPOSE
//  Sequences compute_module through a multi-layer BNN pass: per layer selects the W bank
//  and the X ping-pong read/write banks, then holds en until compute_finish.
//  Sits between the top-level host/testbench control and compute_module.
//  Adds watchdog, abort and done/busy status so the host starts a full network with one pulse.
// PARAMETERS
//  W_SEL_LEN    2   width of W bank select; layer index drives w_sel directly
//  X_SEL_LEN    2   width of X bank select; only values 0/1 are used (ping-pong)
//  LAYER_LEN    2   width of num_layers / layer_idx; max layers = 2**LAYER_LEN-1
//  WDOG_LEN     16  watchdog counter width; timeout = 2**WDOG_LEN-1 cycles in RUN
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst             in   1          asynchronous, active-high reset
//  start           in   1          1-cycle pulse, sampled only in IDLE
//  abort           in   1          level/pulse, stops the pass from any non-IDLE state
//  num_layers      in   LAYER_LEN  layers to run, sampled on accepted start; 0 = no-op pass
//  compute_finish  in   1          from compute_module, sampled only in RUN
//  en              out  1          to compute_module.en, high only in RUN
//  w_sel           out  W_SEL_LEN  W bank = current layer index (zero-extended)
//  x_rd_sel        out  X_SEL_LEN  X bank read this layer = layer_idx[0]
//  x_wr_sel        out  X_SEL_LEN  X bank written this layer = ~layer_idx[0]
//  layer_idx       out  LAYER_LEN  current layer, 0-based
//  busy            out  1          high in ARM/RUN/GAP
//  done            out  1          1-cycle pulse at end of a completed pass
//  timeout_err     out  1          sticky; set on watchdog expiry, cleared by accepted start/rst
// BEHAVIOUR
//  - All outputs registered (Moore). Reset: state=IDLE, en=0, w_sel=0, x_rd_sel=0,
//    x_wr_sel=1, layer_idx=0, busy=0, done=0, timeout_err=0, watchdog=0.
//  - States: IDLE, ARM, RUN, GAP, DONE.
//    IDLE: start & !abort -> latch num_layers, clear timeout_err, layer_idx=0;
//          num_layers==0 -> DONE, else -> ARM.
//    ARM (1 cycle): selects stable for layer_idx, en=0; -> RUN.
//    RUN: en=1, watchdog increments each cycle from 0.
//         compute_finish & last layer -> DONE; compute_finish & not last -> GAP;
//         watchdog == all-ones & !compute_finish -> IDLE, timeout_err=1.
//    GAP (1 cycle): en=0 so compute_module re-arms; layer_idx+1; -> ARM.
//    DONE (1 cycle): done=1, busy=0; -> IDLE.
//  - Latency: start accepted at edge N -> ARM visible N+1, en=1 at N+2.
//    compute_finish seen at edge M -> en=0 at M+1; next layer en=1 at M+3 (GAP, ARM).
//    Last-layer finish at M -> done=1 during M+1 only.
//  - Simultaneous/boundary:
//    start while busy ignored (no relatch); abort beats start in IDLE;
//    abort in ARM/RUN/GAP -> IDLE next edge, en=0, no done, timeout_err unchanged;
//    compute_finish and watchdog expiry same cycle -> finish wins;
//    compute_finish outside RUN ignored; watchdog cleared on every RUN entry;
//    layer_idx never wraps: last layer = num_layers-1 checked before increment;
//    async rst mid-pass -> immediate reset values, en drops asynchronously.
//  - Widths: w_sel = layer_idx zero-extended/truncated to W_SEL_LEN; x selects zero-extended.
// STRUCTURE
//  - Shared include bnn_defs.vh: state encodings (IDLE=0,ARM=1,RUN=2,GAP=3,DONE=4),
//    default W/X_SEL_LEN, X ping-pong bank constants.
//  - Sub-module sched_watchdog (clear, inc, WDOG_LEN counter, expired flag); rest is one FSM.
// TESTING
//  1 rst high 20ns, release; check all outputs at reset values, en=0, x_wr_sel=1.
//  2 num_layers=3, start; model finish 10 cycles after each en rise -> w_sel 0,1,2;
//    x_rd_sel 0,1,0; en low exactly 2 cycles between layers; one done pulse.
//  3 num_layers=0, start -> done 1 cycle later, en never asserted, busy stays 0.
//  4 num_layers=2, never assert finish, WDOG_LEN=4 -> en high 15 cycles, then IDLE,
//    timeout_err=1, no done; new start clears timeout_err.
//  5 abort during RUN of layer 1 -> en=0 next edge, busy=0, no done; start+abort same
//    cycle in IDLE -> stays IDLE; start pulsed while busy -> ignored.
//  6 rst asserted mid-RUN between edges -> en drops before next edge; clean restart passes.

Source files
------------

// File: rtl/layer_scheduler_pkg.sv
// Shared state encoding and bank constants for the BNN layer scheduler.
// Imported by the scheduler FSM and its watchdog.
package layer_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DEF_W_SEL_LEN = 2;
    localparam int DEF_X_SEL_LEN = 2;
    localparam int DEF_LAYER_LEN = 2;
    localparam int DEF_WDOG_LEN  = 16;

    localparam int X_BANK_PING = 0;
    localparam int X_BANK_PONG = 1;

    function automatic logic is_busy(input state_t s);
        return s inside {ST_ARM, ST_RUN, ST_GAP};
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// RUN-phase watchdog for the layer scheduler.
// Flags expiry once a layer has spent 2**WDOG_LEN-1 cycles in RUN.
module sched_watchdog #(
    parameter int WDOG_LEN = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    logic [WDOG_LEN-1:0] r_count;

    // Count includes the current RUN cycle, so the entry clear preloads one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= WDOG_LEN'(1);
        end else if (i_inc) begin
            r_count <= r_count + WDOG_LEN'(1);
        end
    end

    assign o_expired = &r_count;

endmodule

// File: rtl/layer_scheduler.sv
// Sequences compute_module through a multi-layer BNN pass,
// selecting W/X banks per layer with abort, watchdog and done/busy status.
module layer_scheduler
    import layer_scheduler_pkg::*;
#(
    parameter int W_SEL_LEN = DEF_W_SEL_LEN,
    parameter int X_SEL_LEN = DEF_X_SEL_LEN,
    parameter int LAYER_LEN = DEF_LAYER_LEN,
    parameter int WDOG_LEN  = DEF_WDOG_LEN
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [LAYER_LEN-1:0] i_num_layers,
    input  logic                 i_compute_finish,
    output logic                 o_en,
    output logic [W_SEL_LEN-1:0] o_w_sel,
    output logic [X_SEL_LEN-1:0] o_x_rd_sel,
    output logic [X_SEL_LEN-1:0] o_x_wr_sel,
    output logic [LAYER_LEN-1:0] o_layer_idx,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_timeout_err
);

    state_t               r_state;
    state_t               w_next;
    logic [LAYER_LEN-1:0] r_layer_idx;
    logic [LAYER_LEN-1:0] w_layer_next;
    logic [LAYER_LEN-1:0] r_num_layers;
    logic [LAYER_LEN-1:0] w_nl_next;
    logic                 r_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout_err;
    logic                 w_terr_next;
    logic                 w_wd_clear;
    logic                 w_wd_inc;
    logic                 w_expired;
    logic                 w_last;
    logic                 w_odd;

    sched_watchdog #(
        .WDOG_LEN (WDOG_LEN)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_wd_clear),
        .i_inc     (w_wd_inc),
        .o_expired (w_expired)
    );

    assign w_last = (r_layer_idx == r_num_layers - LAYER_LEN'(1));

    always_comb begin
        w_next       = r_state;
        w_layer_next = r_layer_idx;
        w_nl_next    = r_num_layers;
        w_terr_next  = r_timeout_err;
        w_wd_clear   = 1'b0;
        w_wd_inc     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_nl_next    = i_num_layers;
                    w_terr_next  = 1'b0;
                    w_layer_next = '0;
                    w_next = (i_num_layers == '0) ? ST_DONE : ST_ARM;
                end
            end
            ST_ARM: begin
                w_wd_clear = 1'b1;
                w_next = i_abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                w_wd_inc = 1'b1;
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else if (i_compute_finish) begin
                    w_next = w_last ? ST_DONE : ST_GAP;
                end else if (w_expired) begin
                    w_next      = ST_IDLE;
                    w_terr_next = 1'b1;
                end
            end
            ST_GAP: begin
                if (i_abort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_layer_next = r_layer_idx + LAYER_LEN'(1);
                    w_next       = ST_ARM;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Status flags are decoded from the next state so they register with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_layer_idx   <= '0;
            r_num_layers  <= '0;
            r_timeout_err <= 1'b0;
            r_en          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_layer_idx   <= w_layer_next;
            r_num_layers  <= w_nl_next;
            r_timeout_err <= w_terr_next;
            r_en          <= (w_next == ST_RUN);
            r_busy        <= is_busy(w_next);
            r_done        <= (w_next == ST_DONE);
        end
    end

    assign w_odd = r_layer_idx[0];

    assign o_en          = r_en;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_timeout_err = r_timeout_err;
    assign o_layer_idx   = r_layer_idx;
    assign o_w_sel       = W_SEL_LEN'(r_layer_idx);
    assign o_x_rd_sel    = w_odd ? X_SEL_LEN'(X_BANK_PONG)
                                 : X_SEL_LEN'(X_BANK_PING);
    assign o_x_wr_sel    = w_odd ? X_SEL_LEN'(X_BANK_PING)
                                 : X_SEL_LEN'(X_BANK_PONG);

endmodule

// File: tb/tb_layer_scheduler.sv
// Self-checking bench for layer_scheduler: table rows, corner sequences
// and randomized passes against a per-pass expected-trace model.
module tb_layer_scheduler;

    localparam int WD     = 4;
    localparam int WD_LIM = (1 << WD) - 1;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [1:0] i_num_layers = 2'd0;
    logic       i_compute_finish = 1'b0;
    logic       o_en;
    logic [1:0] o_w_sel;
    logic [1:0] o_x_rd_sel;
    logic [1:0] o_x_wr_sel;
    logic [1:0] o_layer_idx;
    logic       o_busy;
    logic       o_done;
    logic       o_timeout_err;

    int n_vec = 0;
    int n_bad = 0;

    layer_scheduler #(
        .W_SEL_LEN (2),
        .X_SEL_LEN (2),
        .LAYER_LEN (2),
        .WDOG_LEN  (WD)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_num_layers     (i_num_layers),
        .i_compute_finish (i_compute_finish),
        .o_en             (o_en),
        .o_w_sel          (o_w_sel),
        .o_x_rd_sel       (o_x_rd_sel),
        .o_x_wr_sel       (o_x_wr_sel),
        .o_layer_idx      (o_layer_idx),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_timeout_err    (o_timeout_err)
    );

    initial forever #5 clk = ~clk;

    // One expected cycle of a pass plus the inputs driven during it.
    typedef struct {
        bit en;
        bit busy;
        bit done;
        int layer;
        bit fin;
        bit abt;
    } ent_t;

    typedef struct {
        int L;
        int d0;
        int d1;
        int d2;
        int ab;
        int x_en;
        int x_done;
        int x_busy;
        bit x_terr;
    } row_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string nm, input bit en, input bit busy,
                             input bit done, input int layer, input bit terr);
        logic [11:0] got;
        logic [11:0] exp;
        got = {o_en, o_busy, o_done, o_layer_idx, o_w_sel,
               o_x_rd_sel, o_x_wr_sel, o_timeout_err};
        exp = {en, busy, done, 2'(layer), 2'(layer),
               2'(layer % 2), 2'(1 - layer % 2), terr};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: {en,busy,done,layer,w_sel,x_rd,x_wr,terr} got %b expected %b",
                     nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Builds the expected cycle trace of one pass from the layer rules,
    // drives it, and compares every cycle plus the idle cycle after it.
    task automatic run_pass(input int L, input int d0, input int d1,
                            input int d2, input int ab,
                            output int n_en, output int n_done,
                            output int n_busy, output bit terr_out);
        ent_t tr[$];
        ent_t e;
        int   d[3];
        bit   tout;
        bit   stop;
        int   lastl;
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        tout = 1'b0;
        stop = 1'b0;
        if (L == 0) begin
            e = '{1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
            tr.push_back(e);
        end else begin
            for (int i = 0; i < L && !stop; i++) begin
                e = '{1'b0, 1'b1, 1'b0, i, 1'b0, 1'b0};
                tr.push_back(e);
                for (int k = 1; k <= WD_LIM; k++) begin
                    e = '{1'b1, 1'b1, 1'b0, i, (k == d[i]), 1'b0};
                    tr.push_back(e);
                    if (k == d[i]) begin
                        e = '{1'b0, (i != L - 1), (i == L - 1), i, 1'b0, 1'b0};
                        tr.push_back(e);
                        break;
                    end
                    if (k == WD_LIM) begin
                        tout = 1'b1;
                        stop = 1'b1;
                    end
                end
            end
        end
        if (ab < tr.size() && tr[ab].busy) begin
            tr[ab].abt = 1'b1;
            while (tr.size() > ab + 1) void'(tr.pop_back());
            tout = 1'b0;
        end
        lastl = tr[tr.size() - 1].layer;

        i_start          = 1'b1;
        i_num_layers     = 2'(L);
        i_abort          = 1'b0;
        i_compute_finish = 1'b0;
        tick();
        n_en   = 0;
        n_done = 0;
        n_busy = 0;
        for (int k = 0; k < tr.size(); k++) begin
            i_start          = 1'($urandom);
            i_num_layers     = 2'($urandom);
            i_abort          = tr[k].abt;
            i_compute_finish = tr[k].en ? tr[k].fin : 1'($urandom);
            check_out($sformatf("pass_L%0d_cyc%0d", L, k), tr[k].en,
                      tr[k].busy, tr[k].done, tr[k].layer, 1'b0);
            n_en   += int'(o_en);
            n_done += int'(o_done);
            n_busy += int'(o_busy);
            tick();
        end
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_compute_finish = 1'b0;
        check_out($sformatf("pass_L%0d_idle", L), 1'b0, 1'b0, 1'b0,
                  lastl, tout);
        terr_out = o_timeout_err;
    endtask

    task automatic run_row(input row_t r, input int idx);
        int n_en;
        int n_done;
        int n_busy;
        bit terr;
        run_pass(r.L, r.d0, r.d1, r.d2, r.ab, n_en, n_done, n_busy, terr);
        check_int($sformatf("row%0d_en_cycles", idx), n_en, r.x_en);
        check_int($sformatf("row%0d_done_pulses", idx), n_done, r.x_done);
        check_int($sformatf("row%0d_busy_cycles", idx), n_busy, r.x_busy);
        check_int($sformatf("row%0d_timeout_err", idx), int'(terr),
                  int'(r.x_terr));
    endtask

    row_t rows[6];

    initial begin
        int n_en;
        int n_done;
        int n_busy;
        bit terr;

        rows[0] = '{3, 10, 10, 10, 99, 30, 1, 35, 1'b0};
        rows[1] = '{0,  1,  1,  1, 99,  0, 1,  0, 1'b0};
        rows[2] = '{2, 20, 20, 20, 99, 15, 0, 16, 1'b1};
        rows[3] = '{2,  4, 10, 10,  9,  7, 0, 10, 1'b0};
        rows[4] = '{1, 15,  1,  1, 99, 15, 1, 16, 1'b0};
        rows[5] = '{3,  1,  1,  1, 99,  3, 1,  8, 1'b0};

        #12;
        check_out("reset_hold", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        #8;
        i_rst = 1'b0;
        tick();
        check_out("reset_released", 1'b0, 1'b0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 3; r++) run_row(rows[r], r);

        // abort beats start in IDLE; sticky timeout survives it
        i_start      = 1'b1;
        i_abort      = 1'b1;
        i_num_layers = 2'd2;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        check_out("start_abort_c1", 1'b0, 1'b0, 1'b0, 0, 1'b1);
        tick();
        check_out("start_abort_c2", 1'b0, 1'b0, 1'b0, 0, 1'b1);

        for (int r = 3; r < 6; r++) run_row(rows[r], r);

        // asynchronous reset in the middle of a RUN cycle
        i_start      = 1'b1;
        i_num_layers = 2'd2;
        tick();
        i_start = 1'b0;
        tick();
        check_out("pre_rst_run", 1'b1, 1'b1, 1'b0, 0, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check_out("async_rst_mid", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #2;
        i_rst = 1'b0;
        tick();
        check_out("after_rst", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_row(rows[0], 6);

        for (int p = 0; p < 40; p++) begin
            run_pass(int'($urandom % 4), 1 + int'($urandom % 17),
                     1 + int'($urandom % 17), 1 + int'($urandom % 17),
                     int'($urandom % 60), n_en, n_done, n_busy, terr);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
